// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and raster types.
// Consumed by the timing generator and downstream VGA stages.
package vga_pkg;

    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;
    localparam int BLINK_D     = 16;

    typedef logic [9:0] vga_coord_t;

    typedef struct packed {
        vga_coord_t row;
        vga_coord_t col;
        logic       hsync;
        logic       vsync;
        logic       is_blank;
    } vga_timing_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered
// active-low sync and active flags derived from the next count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_D,
    parameter int FRONT   = H_FRONT_D,
    parameter int SYNC    = H_SYNC_D,
    parameter int BACK    = H_BACK_D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       sync_n,
    output logic       active,
    output logic       wrap
);

    localparam vga_coord_t LAST    = vga_coord_t'(VISIBLE + FRONT + SYNC + BACK - 1);
    localparam vga_coord_t SYNC_LO = vga_coord_t'(VISIBLE + FRONT);
    localparam vga_coord_t SYNC_HI = vga_coord_t'(VISIBLE + FRONT + SYNC - 1);
    localparam vga_coord_t VIS     = vga_coord_t'(VISIBLE);

    vga_coord_t nxt;

    always_comb begin
        wrap = en && (count == LAST);
        nxt  = count;
        if (wrap) begin
            nxt = '0;
        end else if (en) begin
            nxt = count + 10'd1;
        end
    end

    // Flags follow nxt so they line up with the count they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            sync_n <= 1'b1;
            active <= 1'b1;
        end else begin
            count  <= nxt;
            sync_n <= !((nxt >= SYNC_LO) && (nxt <= SYNC_HI));
            active <= (nxt < VIS);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, syncs, blank and frame events.
// Define VGA_CURSOR_BLINK_EN to enable the cursor blink counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = H_VISIBLE_D,
    parameter int H_FRONT      = H_FRONT_D,
    parameter int H_SYNC       = H_SYNC_D,
    parameter int H_BACK       = H_BACK_D,
    parameter int V_VISIBLE    = V_VISIBLE_D,
    parameter int V_FRONT      = V_FRONT_D,
    parameter int V_SYNC       = V_SYNC_D,
    parameter int V_BACK       = V_BACK_D,
    parameter int BLINK_FRAMES = BLINK_D
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       hsync,
    output logic       vsync,
    output logic       is_blank,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count,
    output logic       cursor_blink
);

    localparam vga_coord_t V_LAST_VIS = vga_coord_t'(V_VISIBLE - 1);

    logic h_active;
    logic v_active;
    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .count  (col),
        .sync_n (hsync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v (
        .clk    (clk),
        .reset  (reset),
        .en     (h_wrap),
        .count  (row),
        .sync_n (vsync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    assign is_blank = !(h_active && v_active);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start  <= 1'b1;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_start  <= v_wrap;
            vblank_start <= h_wrap && (row == V_LAST_VIS);
            if (v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

`ifdef VGA_CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
        end else if (v_wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                cursor_blink <= ~cursor_blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = (BLINK_FRAMES >= 1);
    assign cursor_blink = 1'b1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-geometry instance plus a default
// 640x480 instance, both compared every cycle to a cycle-index model.
module tb_vga_timing_gen;

    localparam int SHV = 8,  SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 6,  SVF = 1, SVS = 2, SVB = 2;
    localparam int SBF = 4;
    localparam int SFT = 165;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [9:0] col_s, row_s, col_d, row_d;
    logic hs_s, vs_s, bl_s, fs_s, vb_s, cb_s;
    logic hs_d, vs_d, bl_d, fs_d, vb_d, cb_d;
    logic [7:0] fc_s, fc_d;

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit running = 0;
    int hs_low_d = 0, vs_low_s = 0, vb_cnt_s = 0, fs_next_s = 0;

    logic [33:0] q_s[$];
    logic [33:0] q_d[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .BLINK_FRAMES(SBF)
    ) dut_s (
        .clk(clk), .reset(reset), .col(col_s), .row(row_s),
        .hsync(hs_s), .vsync(vs_s), .is_blank(bl_s),
        .frame_start(fs_s), .vblank_start(vb_s),
        .frame_count(fc_s), .cursor_blink(cb_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .col(col_d), .row(row_d),
        .hsync(hs_d), .vsync(vs_d), .is_blank(bl_d),
        .frame_start(fs_d), .vblank_start(vb_d),
        .frame_count(fc_d), .cursor_blink(cb_d)
    );

    function automatic logic [33:0] model(int tc, int hv, int hf, int hs,
                                          int hb, int vv, int vf, int vs,
                                          int vb, int bf);
        int ht, vt, c, r, f;
        logic h, v, b, k;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        c = tc % ht;
        r = (tc / ht) % vt;
        f = tc / (ht * vt);
        h = !(c >= hv + hf && c < hv + hf + hs);
        v = !(r >= vv + vf && r < vv + vf + vs);
        b = (c >= hv) || (r >= vv);
`ifdef VGA_CURSOR_BLINK_EN
        k = ((f / bf) % 2) == 0;
`else
        k = 1'b1;
`endif
        return {10'(c), 10'(r), h, v, b, (c == 0 && r == 0),
                (c == 0 && r == vv), 8'(f % 256), k};
    endfunction

    function automatic logic [33:0] exp_s(int tc);
        return model(tc, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SBF);
    endfunction

    function automatic logic [33:0] exp_d(int tc);
        return model(tc, 640, 16, 96, 48, 480, 10, 2, 33, 16);
    endfunction

    task automatic check(string tag, logic [33:0] obs, logic [33:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, want);
        end
    endtask

    function automatic logic [33:0] obs_s();
        return {col_s, row_s, hs_s, vs_s, bl_s, fs_s, vb_s, fc_s, cb_s};
    endfunction

    function automatic logic [33:0] obs_d();
        return {col_d, row_d, hs_d, vs_d, bl_d, fs_d, vb_d, fc_d, cb_d};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (running) t++;
        q_s.push_back(exp_s(t));
        q_d.push_back(exp_d(t));
        @(negedge clk);
        check("small", obs_s(), q_s.pop_front());
        check("dflt", obs_d(), q_d.pop_front());
        if (running && t < 800 && !hs_d) hs_low_d++;
        if (running && t < SFT && !vs_s) vs_low_s++;
        if (running && t < SFT && vb_s) vb_cnt_s++;
        if (running && fs_s && fs_next_s == 0) fs_next_s = t;
        if (running && t == 256 * SFT - 1) check("fc255", 34'(fc_s), 34'd255);
        if (running && t == 256 * SFT) check("fc_wrap", 34'(fc_s), 34'd0);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        running = 1;
        t = 0;
        check("rel_s", obs_s(), exp_s(0));
        check("rel_d", obs_d(), exp_d(0));
    endtask

    initial begin
        repeat (3) tick();
        release_reset();
        repeat (257 * SFT) tick();
        check("hs_low_cnt", 34'(hs_low_d), 34'd96);
        check("vs_low_cnt", 34'(vs_low_s), 34'd30);
        check("vb_pulses", 34'(vb_cnt_s), 34'd1);
        check("frame_period", 34'(fs_next_s), 34'(SFT));

        repeat (65) tick();
        check("pre_rst_row", 34'(row_s), 34'd4);
        @(posedge clk);
        #2 reset = 1'b0;
        running = 0;
        #1;
        check("arst_s", obs_s(), exp_s(0));
        check("arst_d", obs_d(), exp_d(0));
        t = 0;
        repeat (3) tick();
        release_reset();
        repeat (2 * SFT + 5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz text display. Runs on the VGA pixel clock. Produces the pixel coordinates, sync pulses and blanking flag consumed by the VGA controller, which letterboxes, fetches from the frame buffer and pipelines sync by three cycles. Also produces frame-rate events: frame start, vblank pulse, frame counter and cursor blink phase.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- BLINK_FRAMES, 16, frames per cursor blink half-period (>= 1)

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- reset  input  1  reset; asynchronous, active-low
- col  output  10  current pixel column
- row  output  10  current line
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- is_blank  output  1  high outside the visible area
- frame_start  output  1  one-cycle pulse at row 0, col 0
- vblank_start  output  1  one-cycle pulse at row V_VISIBLE, col 0
- frame_count  output  8  frames completed, wraps 255 -> 0
- cursor_blink  output  1  cursor visibility phase

## Operation
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Counters are 10 bits; all parameter sums must be <= 1023.
- col increments every clk. At H_TOTAL-1 it wraps to 0, and row increments. At row V_TOTAL-1 with col H_TOTAL-1, row wraps to 0.
- hsync is low when col is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
- vsync is low when row is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491].
- is_blank = (col >= H_VISIBLE) || (row >= V_VISIBLE).
- frame_count increments on the cycle row and col wrap together.
- cursor_blink toggles when a frame wraps and the internal blink counter reaches BLINK_FRAMES-1; the blink counter then clears.
- No CPU interface and no runtime reconfiguration.

## Timing
- All outputs are registered. Every output is a function of the same (row, col) pair shown on that cycle, so there is zero skew between coordinates, syncs and blank.
- hsync, vsync and is_blank are computed from next-state counter values so they stay aligned with row and col.
- Reset (asynchronous assert, synchronous release on clk):
  - col = 0, row = 0, hsync = 1, vsync = 1, is_blank = 0
  - frame_start = 1, so the first cycle after release is a frame start
  - vblank_start = 0, frame_count = 0, cursor_blink = 1
- Reset mid-frame returns immediately to the reset values. No partial-line completion.
- Pulses are exactly one cycle long. frame_start and vblank_start never coincide.
- Line period is 800 clk; frame period is 420000 clk.

## Configuration
- VGA_CURSOR_BLINK_EN defined: blink counter present; cursor_blink behaves as described above.
- Not defined: blink counter omitted; cursor_blink is constant 1.
- All other outputs are unaffected by the macro.

## Structure
- Package vga_pkg holds:
  - the 640x480 timing localparams used as parameter defaults
  - the typedef vga_coord_t (logic [9:0])
  - the typedef vga_timing_t (struct of row, col, hsync, vsync, is_blank) for downstream stages
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - function: wrapping counter with an enable input, plus registered sync and active flags from VISIBLE/FRONT/SYNC/BACK parameters
  - outputs: count, sync_n, active, wrap

## Test plan
- Release reset: first cycle col=0, row=0, frame_start=1, hsync=1, vsync=1, is_blank=0. Next cycle col=1, frame_start=0.
- Run one line: hsync is low exactly for col 656..751 (96 cycles); is_blank rises at col 640; col wraps 799->0 and row goes 0->1.
- Run one frame: vblank_start pulses once at row 480, col 0; vsync is low for rows 490..491 (1600 cycles); the next frame_start comes 420000 cycles after the first.
- Run 256 frames: frame_count steps 0..255 then wraps to 0. With VGA_CURSOR_BLINK_EN, cursor_blink toggles at frame wraps 16, 32, ... Without it, cursor_blink stays 1.
- Assert reset at row 300, col 400: outputs immediately take the reset values. After release, timing restarts from (0,0) with frame_count=0.
- Check the invariant over a full frame: is_blank == (col>=640 || row>=480) on every cycle.
